// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampling UART receiver (8N1, LSB first, idle-high line).
//
// Each bit is sampled at oversample ticks 7, 8 and 9 of its bit period, and the
// majority of the three samples is the bit value. A start bit that votes high is
// treated as a glitch. A stop bit that votes low raises frame_err, and the
// receiver then waits for the line to return high before looking for a new start.
// Received bytes go into a valid/ready holding register. If that register is
// still full when the next byte completes, the new byte is dropped and overrun
// pulses.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-low reset
//   rx        in   asynchronous serial line
//   data      out  [7:0] received byte, stable while valid
//   valid     out  holding register full
//   ready     in   consumer takes data when valid && ready
//   frame_err out  one-cycle pulse, stop bit sampled low
//   overrun   out  one-cycle pulse, byte dropped because holding register full
//   busy      out  receiver FSM not idle
//
// state | meaning
// IDLE  | waiting for a high->low edge on the synchronized line
// START | start bit: confirm low at mid-bit, else false start
// DATA  | 8 data bits, LSB first
// STOP  | stop bit: high completes the byte, low is a framing error
// BRK   | line held low after a framing error; wait for it to go high
module uart_rx_os #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_s_q, prev_q;
  logic [DIV_W-1:0] div_q;
  logic [3:0]       s_q;
  logic [2:0]       bit_idx_q;
  logic [1:0]       vote_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             frame_err_q;
  logic             overrun_q;

  logic tick, samp9, end_bit, maj, byte_done, ferr_d;

  always_comb begin
    tick    = (state_q != IDLE) && (div_q == DIV_LAST);
    samp9   = tick && (s_q == 4'd9);
    end_bit = tick && (s_q == 4'd15);
    // Samples from ticks 7 and 8 are already stored; the third is the live line.
    maj       = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);
    byte_done = (state_q == STOP) && samp9 && maj;
    ferr_d    = (state_q == STOP) && samp9 && !maj;

    state_d = state_q;
    case (state_q)
      IDLE:    if (prev_q && !rx_s_q) state_d = START;
      START: begin
        if (samp9 && maj)  state_d = IDLE;
        else if (end_bit)  state_d = DATA;
      end
      DATA:    if (end_bit && (bit_idx_q == 3'd7)) state_d = STOP;
      STOP:    if (samp9) state_d = maj ? IDLE : BRK;
      BRK:     if (rx_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_q   <= 1'b0;
      rx_s_q      <= 1'b0;
      prev_q      <= 1'b0;
      div_q       <= '0;
      s_q         <= 4'd0;
      bit_idx_q   <= 3'd0;
      vote_q      <= 2'b00;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      prev_q    <= rx_s_q;

      // In IDLE the counters are held at zero, so a start edge begins a bit
      // period cleanly aligned to the edge.
      if (state_q == IDLE) begin
        div_q <= '0;
        s_q   <= 4'd0;
      end else if (tick) begin
        div_q <= '0;
        s_q   <= s_q + 4'd1;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end

      if (tick && (s_q == 4'd7)) vote_q[0] <= rx_s_q;
      if (tick && (s_q == 4'd8)) vote_q[1] <= rx_s_q;

      if (state_q == START) begin
        bit_idx_q <= 3'd0;
      end else if ((state_q == DATA) && end_bit) begin
        bit_idx_q <= bit_idx_q + 3'd1;
      end

      if ((state_q == DATA) && samp9) shift_q[bit_idx_q] <= maj;

      // A consume in the completion cycle frees the register for the new byte.
      if (byte_done) begin
        if (!valid_q || ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end

      frame_err_q <= ferr_d;
      overrun_q   <= byte_done && valid_q && !ready;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
module tb_uart_rx_os;

  localparam int BIT_CLKS = 432;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_pass   = 0;
  int n_checks = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int rx_cnt   = 0;
  logic [7:0] exp_q[$];

  uart_rx_os dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard: every consumed byte must match the oldest expected one.
  always @(negedge clk) begin
    if (reset) begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (valid && ready) begin
        rx_cnt++;
        chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) chk("sb_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Called just after a rising edge; drives start, 8 data bits, and a stop bit
  // whose level and length are selectable.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_bits);
    rx = 1'b0;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(posedge clk);
      #1;
    end
    rx = stop_val;
    repeat (BIT_CLKS * stop_bits) @(posedge clk);
    #1;
    rx = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    ready = 1'b1;
    idle_cycles(5);
    chk("rst_data", {24'd0, data}, 32'h00);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    idle_cycles(10);

    // Plain frame, consumer always ready.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1);
    idle_cycles(20);
    chk("a5_rx_cnt", rx_cnt, 32'd1);
    chk("a5_valid", {31'd0, valid}, 32'd0);
    chk("a5_busy", {31'd0, busy}, 32'd0);
    chk("a5_ferr_cnt", ferr_cnt, 32'd0);
    chk("a5_ovr_cnt", ovr_cnt, 32'd0);

    // Short low glitch is a false start.
    rx = 1'b0;
    idle_cycles(10);
    chk("glitch_busy_hi", {31'd0, busy}, 32'd1);
    idle_cycles(90);
    rx = 1'b1;
    idle_cycles(200);
    chk("glitch_busy_lo", {31'd0, busy}, 32'd0);
    chk("glitch_rx_cnt", rx_cnt, 32'd1);
    chk("glitch_ferr_cnt", ferr_cnt, 32'd0);
    idle_cycles(BIT_CLKS);

    // Stop bit held low for three bit periods: one frame error, no byte.
    send_frame(8'h3C, 1'b0, 3);
    idle_cycles(BIT_CLKS);
    chk("brk_ferr_cnt", ferr_cnt, 32'd1);
    chk("brk_rx_cnt", rx_cnt, 32'd1);
    chk("brk_valid", {31'd0, valid}, 32'd0);
    chk("brk_busy", {31'd0, busy}, 32'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1);
    idle_cycles(20);
    chk("5a_rx_cnt", rx_cnt, 32'd2);
    chk("5a_ferr_cnt", ferr_cnt, 32'd1);

    // Consumer stalled across two back-to-back frames: second byte overruns.
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1);
    chk("ovr_valid_first", {31'd0, valid}, 32'd1);
    send_frame(8'h22, 1'b1, 1);
    idle_cycles(5);
    chk("ovr_valid", {31'd0, valid}, 32'd1);
    chk("ovr_data", {24'd0, data}, 32'h11);
    chk("ovr_cnt", ovr_cnt, 32'd1);
    ready = 1'b1;
    idle_cycles(1);
    ready = 1'b0;
    chk("drain_valid", {31'd0, valid}, 32'd0);
    chk("drain_data", {24'd0, data}, 32'h11);
    chk("drain_rx_cnt", rx_cnt, 32'd3);
    idle_cycles(BIT_CLKS);

    // Consume in exactly the stop-decision cycle of the next byte.
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1);
    exp_q.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1, 1);
      begin
        // Decision cycle sits 4161 edges after the edge preceding the start bit.
        repeat (4160) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        chk("swap_data", {24'd0, data}, 32'h22);
        chk("swap_valid", {31'd0, valid}, 32'd1);
        chk("swap_ovr", {31'd0, overrun}, 32'd0);
      end
    join
    idle_cycles(5);
    chk("swap_ovr_cnt", ovr_cnt, 32'd1);
    ready = 1'b1;
    idle_cycles(5);
    chk("swap_rx_cnt", rx_cnt, 32'd5);
    chk("swap_valid_after", {31'd0, valid}, 32'd0);

    // Reset in the middle of bit 4, released while the line is still low.
    rx = 1'b0;
    idle_cycles(5 * BIT_CLKS + 200);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    idle_cycles(5);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_valid", {31'd0, valid}, 32'd0);
    chk("mrst_data", {24'd0, data}, 32'h00);
    reset = 1'b1;
    idle_cycles(600);
    chk("mrst_low_no_start", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    idle_cycles(BIT_CLKS);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1);
    idle_cycles(20);
    chk("c3_rx_cnt", rx_cnt, 32'd6);
    chk("c3_ferr_cnt", ferr_cnt, 32'd1);
    chk("c3_data", {24'd0, data}, 32'hC3);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Oversampling UART receiver: the receiving end for the team's `uart_tx` serial stream (8N1, LSB first, idle-high line).
- Samples the asynchronous `rx` line at 16x the baud rate and majority-votes each bit at mid-bit.
- Detects false starts and framing errors.
- Presents each received byte on a valid/ready holding register with overrun reporting, so downstream logic can stall without losing the current byte.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 115200: line bit rate.
- OVERSAMPLE, 16: sample ticks per bit, fixed at 16.
- Derived DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer-truncated (27 at defaults). One bit period = DIV*16 clocks (432 at defaults).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- rx  input  1  asynchronous serial line, idle high.
- data  output  8  received byte; stable while valid=1.
- valid  output  1  data holds an unconsumed byte.
- ready  input  1  consumer accepts data on a cycle where valid&&ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while holding register full and not being drained.
- busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset values: data=0x00, valid=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, all counters 0.
- Two-flop synchronizer (`rx_s`) and previous-sample flop; all three reset to 0. This ensures a start edge requires a high `rx_s` to have been seen after reset.
- Tick generator: counter 0..DIV-1, tick when ==DIV-1.
  - Held at 0 in IDLE.
  - Cleared on start-edge detection so sampling aligns to the edge.
- Sample counter `s` (0..15) advances per tick. Bit samples are taken at s=7,8,9; the majority of 3 is the bit value, decided at s=9. The bit period ends at s=15 tick.
- IDLE:
  - Falling edge (`prev`=1, `rx_s`=0) -> START, clear the tick generator and s.
- START:
  - Majority at s=9 is 1 -> false start; return to IDLE immediately, no outputs.
  - Majority 0 -> at end of bit go to DATA, bit index 0.
- DATA:
  - Majority value shifts into the shift register at position bit index (LSB first).
  - After bit index 7 completes -> STOP.
- STOP, decision at s=9:
  - Majority 1: byte complete, go to IDLE.
  - Majority 0: frame_err pulses for 1 cycle, byte discarded, go to BRK.
- BRK:
  - Wait until `rx_s`=1, then IDLE. No start detection while in BRK.
  - Long breaks therefore produce exactly one frame_err.
- Byte completion (stop decision cycle, call it cycle T):
  - valid=0 -> data loaded and valid=1 at T+1.
  - valid=1 and ready=1 in cycle T -> old byte consumed, new byte loaded, valid stays 1, no overrun.
  - valid=1 and ready=0 -> overrun pulses at T+1, new byte dropped, old data/valid unchanged.
- Handshake:
  - valid&&ready with no completion in the same cycle -> valid=0 next cycle.
  - data holds its value, not cleared.
- Latency: valid rises 1 clock after the s=9 tick of the stop bit, about 9.5 bit periods after the start edge (≈4100 clocks at defaults).
- busy=1 in START/DATA/STOP/BRK and drops the cycle IDLE is re-entered. The next start edge may be detected from the following cycle, so back-to-back frames work.
- Reset asserted mid-frame:
  - All state returns to reset values next cycle; a pending valid byte is lost.
  - After release, a line already low is not a start; reception begins at the next high->low transition.

Test Plan:
- Defaults, ready=1, send frame 0xA5 (432 clk/bit) -> valid pulses 1 cycle with data=0xA5, frame_err=0, overrun=0, busy low afterwards.
- 100-clock low glitch on idle line -> busy high then low before s=9 of first bit period, valid never asserted, no frame_err.
- Send 0x3C with stop bit driven 0 for 3 bit periods, then high -> single frame_err pulse, valid stays 0; subsequent 0x5A received correctly.
- ready=0, send 0x11 then 0x22 back-to-back -> valid=1 with data=0x11 throughout, one overrun pulse at the end of the second frame; raise ready -> valid drops, data stays 0x11.
- ready asserted exactly in the stop-decision cycle of 0x22 while holding 0x11 -> next cycle data=0x22, valid=1, no overrun.
- Assert reset (low) during bit 4 of a frame, release while rx low -> outputs at reset values, no byte or frame_err from the partial frame; next full frame 0xC3 received as 0xC3.
